// File: rtl/fifo_word_unpacker.sv
// Drains W-bit words from a synchronous FIFO and emits them as B-bit beats on valid/ready.
// Beat order: LSB slice first by default; define UNPACK_MSB_FIRST_EN for MSB slice first.
module fifo_word_unpacker #(
  parameter int unsigned W = 32,
  parameter int unsigned B = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_data,
  output logic         fifo_rd_en,
  output logic [B-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic [15:0]  words_done
);

  localparam int unsigned N  = W / B;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [B-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          rd_en_q, rd_en_d;
  logic          busy_q, busy_d;
  logic [15:0]   words_done_q, words_done_d;
  logic          hs;

  // Beat currently at the head of the shift register.
  function automatic logic [B-1:0] head_beat(input logic [W-1:0] v);
`ifdef UNPACK_MSB_FIRST_EN
    return v[W-1 -: B];
`else
    return v[B-1:0];
`endif
  endfunction

  // Advance the shift register so the next beat sits at the head.
  function automatic logic [W-1:0] shift_beat(input logic [W-1:0] v);
`ifdef UNPACK_MSB_FIRST_EN
    return v << B;
`else
    return v >> B;
`endif
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sr_d         = sr_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    words_done_d = words_done_q;
    hs           = (state_q == SEND) && out_ready;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = READ;
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        sr_d        = fifo_data;
        idx_d       = '0;
        out_data_d  = head_beat(fifo_data);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        out_valid_d = 1'b1;
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            words_done_d = words_done_q + 16'd1;
            idx_d        = '0;
            out_valid_d  = 1'b0;
            state_d      = IDLE;
          end else begin
            sr_d       = shift_beat(sr_q);
            idx_d      = idx_q + IW'(1);
            out_data_d = head_beat(sr_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d    = (state_d == READ);
    busy_d     = (state_d != IDLE);
    out_last_d = out_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sr_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sr_q         <= sr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      words_done_q <= words_done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Scoreboard bench for fifo_word_unpacker: FIFO model feeds words, a negedge monitor checks beats.
module tb_fifo_word_unpacker;
  localparam int unsigned W = 32;
  localparam int unsigned B = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd_en;
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [15:0]  words_done;

  int n_cmp  = 0;
  int n_err  = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;

  logic [W-1:0] fq[$];
  logic [B:0]   exp_q[$];
  logic         stall_q = 1'b0;
  logic [B-1:0] held_q  = '0;

  fifo_word_unpacker #(.W(W), .B(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [B-1:0] beat(input logic [W-1:0] w, input int i);
    logic [W-1:0] t;
    t = w;
`ifdef UNPACK_MSB_FIRST_EN
    return t[W-1-B*i -: B];
`else
    return t[B*i +: B];
`endif
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), beat(w, i)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int tgt, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (words_done == 16'(tgt)) break;
    end
    chk("wait_words_done", 32'(words_done), 32'(tgt));
  endtask

  task automatic wait_hs(input int tgt, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (hs_cnt == tgt) break;
    end
    chk("wait_handshakes", 32'(hs_cnt), 32'(tgt));
  endtask

  // Synchronous FIFO model: registered empty flag, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: scoreboard pops, hold-under-backpressure and read-strobe legality.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("rd_en_fifo_nonempty", 32'(fq.size() != 0), 32'd1);
      chk("rd_en_valid_overlap", 32'(out_valid), 32'd0);
    end
    if (stall_q && !rst) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(held_q));
    end
    if (out_valid && out_ready && !rst) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        logic [B:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(out_data), 32'(e[B-1:0]));
        chk("beat_last", 32'(out_last), 32'(e[B]));
      end
    end
    stall_q <= out_valid && !out_ready && !rst;
    held_q  <= out_data;
  end

  initial begin
    int base;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    rst = 1'b0;

    // Empty FIFO: nothing must happen.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
    end

    // Single word: latency and consecutive beats.
    base = hs_cnt;
    push_word(32'h1122_3344);
    tick();
    chk("lat_rd_en_t0", 32'(fifo_rd_en), 32'd0);
    tick();
    chk("lat_rd_en_t1", 32'(fifo_rd_en), 32'd1);
    chk("lat_busy_t1", 32'(busy), 32'd1);
    tick();
    chk("lat_rd_en_t2", 32'(fifo_rd_en), 32'd0);
    chk("lat_valid_t2", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid_t3", 32'(out_valid), 32'd1);
    chk("lat_beat0", 32'(out_data), 32'(beat(32'h1122_3344, 0)));
    chk("lat_last0", 32'(out_last), 32'd0);
    repeat (4) tick();
    chk("single_beats", 32'(hs_cnt), 32'(base + 4));
    chk("single_valid_end", 32'(out_valid), 32'd0);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_words", 32'(words_done), 32'd1);
    chk("single_rd_pulses", 32'(rd_cnt), 32'd1);

    // Three back-to-back words.
    push_word(32'd100);
    push_word(32'd200);
    push_word(32'd300);
    wait_words(4, 200);
    repeat (10) tick();
    chk("three_busy", 32'(busy), 32'd0);
    chk("three_empty", 32'(fifo_empty), 32'd1);
    chk("three_rd_pulses", 32'(rd_cnt), 32'd4);
    chk("three_words", 32'(words_done), 32'd4);

    // Backpressure for 5 cycles on beat 1.
    base = hs_cnt;
    push_word(32'hAABB_CCDD);
    wait_hs(base + 1, 50);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(beat(32'hAABB_CCDD, 1)));
    end
    out_ready = 1'b1;
    wait_words(5, 50);

    // Reset while beat 2 is presented.
    base = hs_cnt;
    push_word(32'hDEAD_BEEF);
    wait_hs(base + 2, 50);
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_words", 32'(words_done), 32'd0);
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    push_word(32'h0102_0304);
    wait_words(1, 50);
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("total_rd_pulses", 32'(rd_cnt), 32'd7);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
